// File: rtl/arvi_pkg.sv
// Shared definitions for the ARVI core: data width, register file geometry
// and the writeback port controller state type.
package arvi_pkg;

   localparam int XLEN    = 32;
   localparam int REG_CNT = 32;
   localparam int REG_AW  = 5;

   typedef enum logic {WB_CLEAR, WB_RUN} wb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or above
// the pointer, wrapping around, as a one-hot vector plus its binary index.
module rr_arbiter #(
   parameter  int N  = 3,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx
);

   logic          found_s;
   logic [IW-1:0] sel_s;

   function automatic int wrap_idx(input int p, input int k);
      int s;
      s = p + k;
      return (s >= N) ? (s - N) : s;
   endfunction

   // Scan the N slots starting at the pointer and keep the first live request
   always_comb begin
      grant   = '0;
      idx     = '0;
      found_s = 1'b0;
      sel_s   = '0;
      for (int k = 0; k < N; k++) begin
         sel_s = IW'(wrap_idx(int'(ptr), k));
         if (!found_s && req[sel_s]) begin
            found_s      = 1'b1;
            grant[sel_s] = 1'b1;
            idx          = sel_s;
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register file write-port controller: zeroes x1..x31 after reset, then
// shares the single write port among N_REQ writeback sources round-robin.
module regfile_wb_arbiter
   import arvi_pkg::*;
#(
   parameter  int N_REQ = 3,
   localparam int GW    = $clog2(N_REQ)
) (
   input  logic                    i_clk,
   input  logic                    i_rstn,
   input  logic [N_REQ-1:0]        i_Req_valid,
   output logic [N_REQ-1:0]        o_Req_ready,
   input  logic [REG_AW*N_REQ-1:0] i_Req_rd,
   input  logic [XLEN*N_REQ-1:0]   i_Req_wd,
   output logic                    o_Wen,
   output logic [REG_AW-1:0]       o_Wnum,
   output logic [XLEN-1:0]         o_Wd,
   output logic                    o_Init_done,
   output logic [GW-1:0]           o_Grant_id
);

   wb_state_t         state_r;
   logic [REG_AW-1:0] cnt_r;
   logic [GW-1:0]     ptr_r;
   logic [N_REQ-1:0]  grant_s;
   logic [GW-1:0]     idx_s;
   logic              xfer_s;
   logic [REG_AW-1:0] sel_rd_s;
   logic [XLEN-1:0]   sel_wd_s;
   logic [GW-1:0]     ptr_nxt_s;

   rr_arbiter #(.N(N_REQ)) u_arb (
      .req   (i_Req_valid),
      .ptr   (ptr_r),
      .grant (grant_s),
      .idx   (idx_s)
   );

   assign o_Grant_id = idx_s;
   assign sel_rd_s   = i_Req_rd[REG_AW*idx_s +: REG_AW];
   assign sel_wd_s   = i_Req_wd[XLEN*idx_s +: XLEN];

   // Ready is only offered once the sweep is over; the grant already implies valid
   always_comb begin
      if (state_r == WB_RUN) begin
         o_Req_ready = grant_s;
         xfer_s      = |(grant_s & i_Req_valid);
      end else begin
         o_Req_ready = '0;
         xfer_s      = 1'b0;
      end
   end

   // Next pointer is one past the winner, wrapping at N_REQ
   always_comb begin
      if (idx_s == GW'(N_REQ - 1)) begin
         ptr_nxt_s = '0;
      end else begin
         ptr_nxt_s = idx_s + GW'(1);
      end
   end

   // State, sweep counter, pointer and registered write-port outputs
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_r     <= WB_CLEAR;
         cnt_r       <= REG_AW'(1);
         ptr_r       <= '0;
         o_Wen       <= 1'b0;
         o_Wnum      <= '0;
         o_Wd        <= '0;
         o_Init_done <= 1'b0;
      end else begin
         case (state_r)
            WB_CLEAR: begin
               o_Wen  <= 1'b1;
               o_Wnum <= cnt_r;
               o_Wd   <= '0;
               cnt_r  <= cnt_r + REG_AW'(1);
               if (cnt_r == REG_AW'(REG_CNT - 1)) begin
                  state_r     <= WB_RUN;
                  o_Init_done <= 1'b1;
               end
            end
            WB_RUN: begin
               if (xfer_s) begin
                  // x0 writes are consumed but never reach the register file
                  o_Wen  <= (sel_rd_s != '0);
                  o_Wnum <= sel_rd_s;
                  o_Wd   <= sel_wd_s;
                  ptr_r  <= ptr_nxt_s;
               end else begin
                  o_Wen <= 1'b0;
               end
            end
            default: begin
               state_r <= WB_CLEAR;
               cnt_r   <= REG_AW'(1);
               o_Wen   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: requester FIFOs drive the DUT,
// a spec-level model predicts grants, port values and register file contents.
module tb_regfile_wb_arbiter;

   localparam int N = 3;

   logic          i_clk = 1'b0;
   logic          i_rstn;
   logic [N-1:0]  i_Req_valid;
   logic [N-1:0]  o_Req_ready;
   logic [5*N-1:0]  i_Req_rd;
   logic [32*N-1:0] i_Req_wd;
   logic          o_Wen;
   logic [4:0]    o_Wnum;
   logic [31:0]   o_Wd;
   logic          o_Init_done;
   logic [1:0]    o_Grant_id;

   regfile_wb_arbiter #(.N_REQ(N)) dut (
      .i_clk       (i_clk),
      .i_rstn      (i_rstn),
      .i_Req_valid (i_Req_valid),
      .o_Req_ready (o_Req_ready),
      .i_Req_rd    (i_Req_rd),
      .i_Req_wd    (i_Req_wd),
      .o_Wen       (o_Wen),
      .o_Wnum      (o_Wnum),
      .o_Wd        (o_Wd),
      .o_Init_done (o_Init_done),
      .o_Grant_id  (o_Grant_id)
   );

   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_fail   = 0;

   // requester FIFOs: a pending entry is held on the bus until accepted
   logic [4:0]  f_rd [N][512];
   logic [31:0] f_wd [N][512];
   int          hd [N];
   int          tl [N];

   // register files: one fed by the DUT port, one by the model
   logic [31:0] rf_act [32];
   logic [31:0] rf_mod [32];

   // model state: edges since reset, pointer, expected port registers
   int          m_sweep;
   int          m_ptr;
   logic        m_wen;
   logic [4:0]  m_wnum;
   logic [31:0] m_wd;
   logic        m_done;
   int          last_grant;
   int          grants [6];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int r, input logic [4:0] rd, input logic [31:0] wd);
      f_rd[r][tl[r]] = rd;
      f_wd[r][tl[r]] = wd;
      tl[r]++;
   endtask

   function automatic bit busy();
      for (int r = 0; r < N; r++) if (hd[r] != tl[r]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic drive();
      for (int r = 0; r < N; r++) begin
         i_Req_valid[r]        = (hd[r] != tl[r]);
         i_Req_rd[5*r +: 5]    = (hd[r] != tl[r]) ? f_rd[r][hd[r]] : 5'd0;
         i_Req_wd[32*r +: 32]  = (hd[r] != tl[r]) ? f_wd[r][hd[r]] : 32'd0;
      end
   endtask

   task automatic model_reset();
      m_sweep = 0;
      m_ptr   = 0;
      m_wen   = 1'b0;
      m_wnum  = 5'd0;
      m_wd    = 32'd0;
      m_done  = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_wen"},   {63'd0, o_Wen},       64'd0);
      chk({tag, "_wnum"},  {59'd0, o_Wnum},      64'd0);
      chk({tag, "_wd"},    {32'd0, o_Wd},        64'd0);
      chk({tag, "_done"},  {63'd0, o_Init_done}, 64'd0);
      chk({tag, "_ready"}, {61'd0, o_Req_ready}, 64'd0);
   endtask

   // One clock: called at a falling edge, returns at the next falling edge
   task automatic tick();
      int          w;
      logic [2:0]  exp_rdy;
      logic        p_wen;
      logic [4:0]  p_wnum;
      logic [31:0] p_wd;
      drive();
      #1;
      w = -1;
      if (m_sweep >= 31) begin
         for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (w < 0 && hd[j] != tl[j]) w = j;
         end
      end
      exp_rdy = (w >= 0) ? (3'b001 << w) : 3'b000;
      chk("ready", {61'd0, o_Req_ready}, {61'd0, exp_rdy});
      if (w >= 0) chk("grant_id", {62'd0, o_Grant_id}, 64'(w));
      last_grant = w;
      p_wen  = o_Wen;
      p_wnum = o_Wnum;
      p_wd   = o_Wd;
      @(posedge i_clk);
      if (p_wen) rf_act[p_wnum] = p_wd;
      if (m_wen) rf_mod[m_wnum] = m_wd;
      if (m_sweep < 31) begin
         m_sweep++;
         m_wen  = 1'b1;
         m_wnum = 5'(m_sweep);
         m_wd   = 32'd0;
         m_done = (m_sweep >= 31);
      end else if (w >= 0) begin
         m_wnum = f_rd[w][hd[w]];
         m_wd   = f_wd[w][hd[w]];
         m_wen  = (m_wnum != 5'd0);
         m_ptr  = (w + 1) % N;
         hd[w]++;
      end else begin
         m_wen = 1'b0;
      end
      #1;
      chk("wen",  {63'd0, o_Wen},       {63'd0, m_wen});
      if (m_wen) begin
         chk("wnum", {59'd0, o_Wnum}, {59'd0, m_wnum});
         chk("wd",   {32'd0, o_Wd},   {32'd0, m_wd});
      end
      chk("init_done", {63'd0, o_Init_done}, {63'd0, m_done});
      @(negedge i_clk);
   endtask

   initial begin
      for (int r = 0; r < N; r++) begin hd[r] = 0; tl[r] = 0; end
      for (int i = 0; i < 32; i++) begin
         rf_act[i] = (i == 0) ? 32'd0 : (32'hBAD0_0000 + 32'(i));
         rf_mod[i] = rf_act[i];
      end
      i_Req_valid = '0;
      i_Req_rd    = '0;
      i_Req_wd    = '0;
      model_reset();
      last_grant = -1;
      i_rstn = 1'b0;
      #1;
      chk_reset_outputs("por");
      @(negedge i_clk);
      i_rstn = 1'b1;

      // clear sweep with no requests, plus one idle cycle afterwards
      for (int i = 0; i < 32; i++) tick();
      for (int i = 0; i < 32; i++) chk("sweep_zero", {32'd0, rf_act[i]}, 64'd0);

      // single requester 1 write to x5
      push(1, 5'd5, 32'hDEAD_BEEF);
      tick();
      chk("req1_granted", 64'(last_grant), 64'd1);
      tick();
      tick();
      chk("x5_value", {32'd0, rf_act[5]}, 64'h0000_0000_DEAD_BEEF);

      // requester 2 alone moves the pointer to 0, then full contention
      push(2, 5'd3, 32'h3333_0000);
      tick();
      for (int r = 0; r < N; r++) begin
         push(r, 5'(10 + r), 32'h1000_0000 + 32'(r));
         push(r, 5'(20 + r), 32'h2000_0000 + 32'(r));
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         grants[i] = last_grant;
      end
      for (int i = 0; i < 6; i++) chk("rr_order", 64'(grants[i]), 64'(i % 3));

      // write to x0 is accepted but suppressed
      push(0, 5'd0, 32'h1234_5678);
      tick();
      chk("x0_granted", 64'(last_grant), 64'd0);
      tick();
      tick();
      chk("x0_value", {32'd0, rf_act[0]}, 64'd0);

      // pointer now 1: requester 2 then 0, both to x7
      push(0, 5'd7, 32'h0000_000A);
      push(2, 5'd7, 32'h0000_000B);
      tick();
      chk("same_rd_first", 64'(last_grant), 64'd2);
      tick();
      chk("same_rd_second", 64'(last_grant), 64'd0);
      tick();
      tick();
      chk("x7_value", {32'd0, rf_act[7]}, 64'h0000_0000_0000_000A);

      // randomized traffic
      for (int c = 0; c < 300; c++) begin
         for (int r = 0; r < N; r++)
            if ($urandom_range(0, 3) == 0) push(r, 5'($urandom_range(0, 31)), $urandom);
         tick();
      end
      for (int i = 0; i < 200 && busy(); i++) tick();
      chk("drained", {63'd0, busy()}, 64'd0);
      tick();
      tick();
      for (int i = 0; i < 32; i++) chk("rf_random", {32'd0, rf_act[i]}, {32'd0, rf_mod[i]});

      // reset right after an accept: the pending write is lost, sweep restarts
      push(2, 5'd9, 32'h5555_5555);
      tick();
      i_rstn = 1'b0;
      model_reset();
      #1;
      chk_reset_outputs("rst_async");
      @(posedge i_clk);
      #1;
      chk_reset_outputs("rst_hold");
      @(negedge i_clk);
      i_rstn = 1'b1;
      push(2, 5'd11, 32'h7777_7777);
      for (int i = 0; i < 31; i++) tick();
      tick();
      chk("post_rst_grant", 64'(last_grant), 64'd2);
      tick();
      tick();
      chk("x9_swept", {32'd0, rf_act[9]}, 64'd0);
      for (int i = 0; i < 32; i++) chk("rf_final", {32'd0, rf_act[i]}, {32'd0, rf_mod[i]});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
